// File: rtl/shared_register_arbiter_pkg.sv
// Common types and helpers for the shared register arbiter.
// Latency: none; declarations only.
// Backpressure: not applicable.
package shared_register_arbiter_pkg;

    // Arbiter FSM: waiting for a requester, or an owner holds the register
    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    // Index width that stays at least one bit for degenerate sizes
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_register_arbiter_rr_priority_picker.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the winner.
module rr_priority_picker
    import shared_register_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the closest request to ptr wins last
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                winner  = cand_idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_register_arbiter.sv
// Shares one register among NUM_REQ requesters with round-robin grant and capped locking.
// Latency: request edge k -> grant at k+1 -> access and one-cycle ack at k+2 (falling edges).
// Backpressure: requesters hold Req until Ack; a dropped Req abandons the grant without access.
module shared_register_arbiter
    import shared_register_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_HOLD   = 4,
    localparam int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic [NUM_REQ-1:0]            Req_In,
    input  logic [NUM_REQ-1:0]            Wr_En_In,
    input  logic [NUM_REQ-1:0]            Lock_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Wr_Data_In,
    output logic [NUM_REQ-1:0]            Grant_Out,
    output logic [NUM_REQ-1:0]            Ack_Out,
    output logic [DATA_WIDTH-1:0]         Rd_Data_Out,
    output logic                          Busy_Out,
    output logic [IDX_W-1:0]              Owner_Out
);

    localparam int BEAT_W = idx_width(MAX_HOLD + 1);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [BEAT_W-1:0]       beat_inc;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [IDX_W-1:0]        owner_next_ptr;
    logic [DATA_WIDTH-1:0]   wr_slice;
    logic [IDX_W-1:0]        pick_winner;
    logic                    pick_any;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (Req_In),
        .ptr     (ptr_q),
        .winner  (pick_winner),
        .any_req (pick_any)
    );

    // Owner's write data slice and the pointer position just past the owner
    always_comb begin
        wr_slice = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                wr_slice = Wr_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        owner_next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        beat_inc       = beat_q + BEAT_W'(1);
    end

    // Next-state: arbitrate in IDLE, perform or abandon the owner's access in GRANTED
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        data_d  = data_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANTED;
                    owner_d = pick_winner;
                    beat_d  = '0;
                end
            end
            GRANTED: begin
                if (Req_In[owner_q]) begin
                    if (Wr_En_In[owner_q]) begin
                        data_d = wr_slice;
                    end
                    ack_d[owner_q] = 1'b1;
                    beat_d         = beat_inc;
                    // Lock extends the grant only until the hold cap is reached
                    if (!(Lock_In[owner_q] && (beat_inc < BEAT_W'(MAX_HOLD)))) begin
                        state_d = IDLE;
                        ptr_d   = owner_next_ptr;
                    end
                end else begin
                    state_d = IDLE;
                    ptr_d   = owner_next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; updates on the falling clock edge, reset wins immediately
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Outputs decoded from registered state; grant is one-hot of owner while busy
    always_comb begin
        Grant_Out = '0;
        if (state_q == GRANTED) begin
            Grant_Out[owner_q] = 1'b1;
        end
        Busy_Out    = (state_q == GRANTED);
        Ack_Out     = ack_q;
        Rd_Data_Out = data_q;
        Owner_Out   = owner_q;
    end

endmodule

// File: tb/tb_shared_register_arbiter.sv
// Directed bench for shared_register_arbiter with NUM_REQ=4, DATA_WIDTH=8, MAX_HOLD=4.
// Latency: inputs driven and outputs sampled 2 time units after each falling edge.
// Backpressure: requests are held until the expected ack, then dropped.
module tb_shared_register_arbiter;

    logic        Clk_In;
    logic        Reset_In;
    logic [3:0]  Req_In;
    logic [3:0]  Wr_En_In;
    logic [3:0]  Lock_In;
    logic [31:0] Wr_Data_In;
    logic [3:0]  Grant_Out;
    logic [3:0]  Ack_Out;
    logic [7:0]  Rd_Data_Out;
    logic        Busy_Out;
    logic [1:0]  Owner_Out;

    int checks = 0;
    int errors = 0;

    shared_register_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_HOLD   (4)
    ) dut (
        .Clk_In      (Clk_In),
        .Reset_In    (Reset_In),
        .Req_In      (Req_In),
        .Wr_En_In    (Wr_En_In),
        .Lock_In     (Lock_In),
        .Wr_Data_In  (Wr_Data_In),
        .Grant_Out   (Grant_Out),
        .Ack_Out     (Ack_Out),
        .Rd_Data_Out (Rd_Data_Out),
        .Busy_Out    (Busy_Out),
        .Owner_Out   (Owner_Out)
    );

    initial begin
        Clk_In = 1'b0;
        forever #5 Clk_In = ~Clk_In;
    end

    task automatic tick();
        @(negedge Clk_In);
        #2;
    endtask

    task automatic do_reset();
        Req_In = '0; Wr_En_In = '0; Lock_In = '0; Wr_Data_In = '0;
        Reset_In = 1'b1;
        #2;
        Reset_In = 1'b0;
    endtask

    task automatic test_reset();
        Req_In = '0; Wr_En_In = '0; Lock_In = '0; Wr_Data_In = '0;
        Reset_In = 1'b1;
        #3;
        Reset_In = 1'b0;
        Req_In = 4'b1000; Wr_En_In = 4'b1000; Wr_Data_In[31:24] = 8'h5A;
        tick();
        checks++; if (Grant_Out !== 4'b1000) begin errors++; $display("FAIL rst_pre_grant got %b want %b", Grant_Out, 4'b1000); end
        tick();
        checks++; if (Ack_Out !== 4'b1000) begin errors++; $display("FAIL rst_pre_ack got %b want %b", Ack_Out, 4'b1000); end
        checks++; if (Rd_Data_Out !== 8'h5A) begin errors++; $display("FAIL rst_pre_data got %h want %h", Rd_Data_Out, 8'h5A); end
        checks++; if (Owner_Out !== 2'd3) begin errors++; $display("FAIL rst_pre_owner got %0d want %0d", Owner_Out, 3); end
        // Mid-cycle reset, no clock edge before sampling
        #1 Reset_In = 1'b1;
        #1;
        checks++; if (Rd_Data_Out !== 8'h00) begin errors++; $display("FAIL rst_data got %h want %h", Rd_Data_Out, 8'h00); end
        checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL rst_ack got %b want %b", Ack_Out, 4'b0000); end
        checks++; if (Grant_Out !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b want %b", Grant_Out, 4'b0000); end
        checks++; if (Busy_Out !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want %b", Busy_Out, 1'b0); end
        checks++; if (Owner_Out !== 2'd0) begin errors++; $display("FAIL rst_owner got %0d want %0d", Owner_Out, 0); end
        #1 Reset_In = 1'b0;
        Req_In = '0; Wr_En_In = '0;
    endtask

    task automatic test_single_write();
        Req_In = 4'b0100; Wr_En_In = 4'b0100; Wr_Data_In[23:16] = 8'hA5;
        tick();
        checks++; if (Grant_Out !== 4'b0100) begin errors++; $display("FAIL sw_grant got %b want %b", Grant_Out, 4'b0100); end
        checks++; if (Busy_Out !== 1'b1) begin errors++; $display("FAIL sw_busy got %b want %b", Busy_Out, 1'b1); end
        checks++; if (Owner_Out !== 2'd2) begin errors++; $display("FAIL sw_owner got %0d want %0d", Owner_Out, 2); end
        checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL sw_early_ack got %b want %b", Ack_Out, 4'b0000); end
        tick();
        checks++; if (Ack_Out !== 4'b0100) begin errors++; $display("FAIL sw_ack got %b want %b", Ack_Out, 4'b0100); end
        checks++; if (Rd_Data_Out !== 8'hA5) begin errors++; $display("FAIL sw_data got %h want %h", Rd_Data_Out, 8'hA5); end
        checks++; if (Busy_Out !== 1'b0) begin errors++; $display("FAIL sw_busy_after got %b want %b", Busy_Out, 1'b0); end
        Req_In = '0; Wr_En_In = '0;
        tick();
        checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL sw_ack_pulse got %b want %b", Ack_Out, 4'b0000); end
        checks++; if (Owner_Out !== 2'd2) begin errors++; $display("FAIL sw_owner_hold got %0d want %0d", Owner_Out, 2); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        do_reset();
        Req_In = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            tick();
            checks++; if (Grant_Out !== exp_oh) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, Grant_Out, exp_oh); end
            checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL rr_noack%0d got %b want %b", k, Ack_Out, 4'b0000); end
            tick();
            checks++; if (Ack_Out !== exp_oh) begin errors++; $display("FAIL rr_ack%0d got %b want %b", k, Ack_Out, exp_oh); end
        end
        Req_In = '0;
        tick();
    endtask

    task automatic test_lock_cap();
        logic [7:0] exp_d;
        do_reset();
        Req_In = 4'b1010; Lock_In = 4'b0010; Wr_En_In = 4'b0010;
        tick();
        checks++; if (Grant_Out !== 4'b0010) begin errors++; $display("FAIL lk_grant got %b want %b", Grant_Out, 4'b0010); end
        for (int b = 0; b < 4; b++) begin
            exp_d = 8'h20 + 8'(b);
            Wr_Data_In[15:8] = exp_d;
            tick();
            checks++; if (Ack_Out !== 4'b0010) begin errors++; $display("FAIL lk_ack%0d got %b want %b", b, Ack_Out, 4'b0010); end
            checks++; if (Rd_Data_Out !== exp_d) begin errors++; $display("FAIL lk_data%0d got %h want %h", b, Rd_Data_Out, exp_d); end
            checks++; if (Grant_Out !== ((b < 3) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL lk_hold%0d got %b want %b", b, Grant_Out, ((b < 3) ? 4'b0010 : 4'b0000)); end
        end
        tick();
        checks++; if (Grant_Out !== 4'b1000) begin errors++; $display("FAIL lk_pass got %b want %b", Grant_Out, 4'b1000); end
        checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL lk_fifth_ack got %b want %b", Ack_Out, 4'b0000); end
        tick();
        checks++; if (Ack_Out !== 4'b1000) begin errors++; $display("FAIL lk_ack3 got %b want %b", Ack_Out, 4'b1000); end
        checks++; if (Rd_Data_Out !== 8'h23) begin errors++; $display("FAIL lk_read got %h want %h", Rd_Data_Out, 8'h23); end
        Req_In = '0; Lock_In = '0; Wr_En_In = '0;
        tick();
    endtask

    task automatic test_abort();
        // Serve requester 0 so the pointer sits at 1 before the abort
        Req_In = 4'b0001; Wr_En_In = '0;
        tick();
        tick();
        checks++; if (Ack_Out !== 4'b0001) begin errors++; $display("FAIL ab_pre_ack got %b want %b", Ack_Out, 4'b0001); end
        Req_In = 4'b1000; Wr_En_In = 4'b1000; Wr_Data_In[31:24] = 8'hEE;
        tick();
        checks++; if (Grant_Out !== 4'b1000) begin errors++; $display("FAIL ab_grant got %b want %b", Grant_Out, 4'b1000); end
        Req_In = '0;
        tick();
        checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL ab_ack got %b want %b", Ack_Out, 4'b0000); end
        checks++; if (Busy_Out !== 1'b0) begin errors++; $display("FAIL ab_busy got %b want %b", Busy_Out, 1'b0); end
        checks++; if (Rd_Data_Out !== 8'h23) begin errors++; $display("FAIL ab_data got %h want %h", Rd_Data_Out, 8'h23); end
        // Pointer now 0: requester 0 beats requester 3
        Req_In = 4'b1001; Wr_En_In = '0;
        tick();
        checks++; if (Grant_Out !== 4'b0001) begin errors++; $display("FAIL ab_ptr got %b want %b", Grant_Out, 4'b0001); end
        tick();
        checks++; if (Ack_Out !== 4'b0001) begin errors++; $display("FAIL ab_post_ack got %b want %b", Ack_Out, 4'b0001); end
        Req_In = '0;
        tick();
    endtask

    task automatic test_reset_granted();
        do_reset();
        Req_In = 4'b0100; Wr_En_In = 4'b0100; Wr_Data_In[23:16] = 8'h3C;
        tick();
        checks++; if (Grant_Out !== 4'b0100) begin errors++; $display("FAIL rg_grant got %b want %b", Grant_Out, 4'b0100); end
        Reset_In = 1'b1;
        tick();
        checks++; if (Rd_Data_Out !== 8'h00) begin errors++; $display("FAIL rg_data got %h want %h", Rd_Data_Out, 8'h00); end
        checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL rg_ack got %b want %b", Ack_Out, 4'b0000); end
        checks++; if (Grant_Out !== 4'b0000) begin errors++; $display("FAIL rg_grant_clr got %b want %b", Grant_Out, 4'b0000); end
        Reset_In = 1'b0;
        Req_In = '0; Wr_En_In = '0;
        tick();
        checks++; if (Busy_Out !== 1'b0) begin errors++; $display("FAIL rg_idle got %b want %b", Busy_Out, 1'b0); end
        checks++; if (Rd_Data_Out !== 8'h00) begin errors++; $display("FAIL rg_data_after got %h want %h", Rd_Data_Out, 8'h00); end
        checks++; if (Ack_Out !== 4'b0000) begin errors++; $display("FAIL rg_ack_after got %b want %b", Ack_Out, 4'b0000); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_lock_cap();
        test_abort();
        test_reset_granted();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
